// File: rtl/pipe_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: the per-stage entry record
// and the width helper for the forwarding-select outputs.
package pipe_scoreboard_pkg;

    // Entries carry rd at a fixed maximum width; REG_W may be anything up to this.
    localparam int MAX_REG_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic                 wen;
        logic                 load;
    } entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: decode drives the instruction
// fields and flush (master), the scoreboard answers stall/forwarding (slave).
interface pipe_scoreboard_if
    import pipe_scoreboard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int SEL_W = sel_width(DEPTH);

    logic             d_valid;
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_rs_used;
    logic             d_rt_used;
    logic [REG_W-1:0] d_rd;
    logic             d_reg_write_en;
    logic             d_mem_read_en;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rt_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd,
               d_reg_write_en, d_mem_read_en, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rd,
               d_reg_write_en, d_mem_read_en, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

endinterface

// File: rtl/pipe_src_match.sv
// Youngest-producer search for one source operand across the tracked stages.
// Build option: PIPE_FORWARD_EN enables forwarding from ready stages.
module pipe_src_match
    import pipe_scoreboard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = sel_width(DEPTH)
) (
    input  entry_t           entries [1:DEPTH],
    input  logic [REG_W-1:0] src,
    input  logic             used,
    output logic [SEL_W-1:0] sel,
    output logic             hazard
);

    logic [DEPTH:1] hit;
    logic [DEPTH:1] loads;

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
        assign hit[gi] = used && (src != '0) && entries[gi].valid && entries[gi].wen &&
                         (entries[gi].rd == MAX_REG_W'(src));
        assign loads[gi] = entries[gi].load;
    end

`ifdef PIPE_FORWARD_EN
    int   hit_stage;
    logic hit_load;

    always_comb begin
        hit_stage = 0;
        hit_load  = 1'b0;
        // Scan oldest to youngest so the youngest match wins.
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit[k]) begin
                hit_stage = k;
                hit_load  = loads[k];
            end
        end
        sel    = '0;
        hazard = 1'b0;
        if (hit_stage != 0) begin
            if (hit_stage >= (hit_load ? LOAD_READY : ALU_READY)) begin
                sel = SEL_W'(hit_stage);
            end else begin
                hazard = 1'b1;
            end
        end
    end
`else
    logic unused_loads;
    assign unused_loads = ^loads;
    // No forwarding paths: any in-flight producer must drain to the register file.
    assign sel    = '0;
    assign hazard = |hit;
`endif

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard for the in-order pipeline: tracks DEPTH downstream stages,
// raises stall and forwarding selects for decode. Build option: PIPE_FORWARD_EN.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_scoreboard_if.slave sb
);

    localparam int SEL_W = sel_width(DEPTH);

    entry_t           entries_q [1:DEPTH];
    entry_t           entries_d [1:DEPTH];
    entry_t           issue_entry;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             hazard_rs;
    logic             hazard_rt;
    logic             stall;
    logic [SEL_W-1:0] sel_rs;
    logic [SEL_W-1:0] sel_rt;

    pipe_src_match #(
        .REG_W(REG_W), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rs (
        .entries(entries_q), .src(sb.d_rs), .used(sb.d_rs_used),
        .sel(sel_rs), .hazard(hazard_rs)
    );

    pipe_src_match #(
        .REG_W(REG_W), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rt (
        .entries(entries_q), .src(sb.d_rt), .used(sb.d_rt_used),
        .sel(sel_rt), .hazard(hazard_rt)
    );

    // A flushed decode slot never stalls, so flush beats any hazard.
    assign stall = sb.d_valid & ~sb.flush & (hazard_rs | hazard_rt);

    always_comb begin
        issue_entry = '0;
        if (sb.d_valid && !stall && !sb.flush) begin
            issue_entry.valid = 1'b1;
            issue_entry.rd    = MAX_REG_W'(sb.d_rd);
            issue_entry.wen   = sb.d_reg_write_en;
            issue_entry.load  = sb.d_mem_read_en;
        end
    end

    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_shift
        if (gi == 1) begin : g_head
            assign entries_d[gi] = issue_entry;
        end else begin : g_tail
            assign entries_d[gi] = entries_q[gi-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 1; k <= DEPTH; k++) begin
            entries_q[k] <= rst ? '0 : entries_d[k];
        end
        stall_cnt_q <= rst ? '0 : stall_cnt_d;
    end

    assign sb.stall      = stall;
    assign sb.fwd_rs_sel = sel_rs;
    assign sb.fwd_rt_sel = sel_rt;
    assign sb.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Randomized and directed bench for pipe_scoreboard against an issue-history
// reference model; a second instance with a 2-bit counter covers saturation.
module tb_pipe_scoreboard;
    import pipe_scoreboard_pkg::*;

    localparam int REG_W      = 4;
    localparam int DEPTH      = 3;
    localparam int ALU_READY  = 1;
    localparam int LOAD_READY = 2;

    typedef struct {
        bit valid;
        int rs;
        int rt;
        bit rs_used;
        bit rt_used;
        int rd;
        bit wen;
        bit load;
        bit flush;
    } ins_t;

    typedef struct {
        bit valid;
        int rd;
        bit wen;
        bit load;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(16)) sbif ();
    pipe_scoreboard_if #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(2))  sbif2 ();

    assign sbif2.d_valid        = sbif.d_valid;
    assign sbif2.d_rs           = sbif.d_rs;
    assign sbif2.d_rt           = sbif.d_rt;
    assign sbif2.d_rs_used      = sbif.d_rs_used;
    assign sbif2.d_rt_used      = sbif.d_rt_used;
    assign sbif2.d_rd           = sbif.d_rd;
    assign sbif2.d_reg_write_en = sbif.d_reg_write_en;
    assign sbif2.d_mem_read_en  = sbif.d_mem_read_en;
    assign sbif2.flush          = sbif.flush;

    pipe_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
                      .LOAD_READY(LOAD_READY), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .sb(sbif));

    pipe_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
                      .LOAD_READY(LOAD_READY), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst), .sb(sbif2));

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    rec_t hist[$];          // hist[k-1] = instruction now in stage k
    int   cnt_m  = 0;
    int   cnt2_m = 0;
    logic obs_stall;
    logic [31:0] obs_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ins_t mk(bit v, int rs, int rt, bit rsu, bit rtu,
                                int rd, bit wen, bit ld, bit fl);
        ins_t i;
        i.valid = v;  i.rs = rs; i.rt = rt; i.rs_used = rsu; i.rt_used = rtu;
        i.rd = rd;    i.wen = wen; i.load = ld; i.flush = fl;
        return i;
    endfunction

    function automatic void model_clear();
        rec_t b;
        b.valid = 0; b.rd = 0; b.wen = 0; b.load = 0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
        cnt_m  = 0;
        cnt2_m = 0;
    endfunction

    // Youngest in-flight writer of s decides: forwardable if old enough, else hazard.
    function automatic void model_src(input int s, input bit used, output bit haz, output int sel);
        int rdy;
        haz = 0;
        sel = 0;
        if (!used || s == 0) return;
        for (int age = 1; age <= DEPTH; age++) begin
            if (hist[age-1].valid && hist[age-1].wen && hist[age-1].rd == s) begin
`ifdef PIPE_FORWARD_EN
                rdy = hist[age-1].load ? LOAD_READY : ALU_READY;
                if (age >= rdy) sel = age;
                else haz = 1;
`else
                rdy = 0;
                haz = 1;
`endif
                return;
            end
        end
    endfunction

    task automatic step(input ins_t i, input bit do_rst, output bit exp_stall);
        bit   hz_rs, hz_rt;
        int   sel_rs, sel_rt;
        rec_t r;
        @(negedge clk);
        cyc++;
        sbif.d_valid        = i.valid;
        sbif.d_rs           = REG_W'(i.rs);
        sbif.d_rt           = REG_W'(i.rt);
        sbif.d_rs_used      = i.rs_used;
        sbif.d_rt_used      = i.rt_used;
        sbif.d_rd           = REG_W'(i.rd);
        sbif.d_reg_write_en = i.wen;
        sbif.d_mem_read_en  = i.load;
        sbif.flush          = i.flush;
        rst                 = do_rst;
        #1;
        model_src(i.rs, i.rs_used, hz_rs, sel_rs);
        model_src(i.rt, i.rt_used, hz_rt, sel_rt);
        exp_stall = i.valid && !i.flush && (hz_rs || hz_rt);
        obs_stall = sbif.stall;
        obs_cnt   = 32'(sbif.stall_cnt);
        check_val("stall",      32'(sbif.stall),      32'(exp_stall));
        check_val("fwd_rs_sel", 32'(sbif.fwd_rs_sel), sel_rs);
        check_val("fwd_rt_sel", 32'(sbif.fwd_rt_sel), sel_rt);
        check_val("stall_cnt",  32'(sbif.stall_cnt),  cnt_m);
        check_val("stall_cnt2", 32'(sbif2.stall_cnt), cnt2_m);
        $display("cyc=%0d rst=%0d v=%0d fl=%0d rs=%0d/%0d rt=%0d/%0d rd=%0d w=%0d ld=%0d -> stall=%0d sel=%0d/%0d cnt=%0d",
                 cyc, do_rst, i.valid, i.flush, i.rs, i.rs_used, i.rt, i.rt_used, i.rd, i.wen,
                 i.load, sbif.stall, sbif.fwd_rs_sel, sbif.fwd_rt_sel, sbif.stall_cnt);
        if (do_rst) begin
            model_clear();
        end else begin
            r.valid = i.valid && !exp_stall && !i.flush;
            r.rd    = r.valid ? i.rd : 0;
            r.wen   = r.valid && i.wen;
            r.load  = r.valid && i.load;
            hist.push_front(r);
            void'(hist.pop_back());
            if (exp_stall) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt2_m < 3) cnt2_m++;
            end
        end
    endtask

    task automatic issue(input ins_t i, output int stalls);
        bit s;
        stalls = 0;
        do begin
            step(i, 1'b0, s);
            if (s) stalls++;
        end while (s && stalls < 12);
        if (stalls >= 12) check_val("issue_bound", stalls, 0);
    endtask

    task automatic drain();
        bit s;
        repeat (DEPTH) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, s);
    endtask

    initial begin
        ins_t nop, lw3, use3, cur;
        int   n, exp_lu, exp_dep, cnt_before;
        bit   s, last_stall;

        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw3  = mk(1, 1, 0, 1, 0, 3, 1, 1, 0);
        use3 = mk(1, 3, 5, 1, 1, 4, 1, 0, 0);
`ifdef PIPE_FORWARD_EN
        exp_lu  = 1;
        exp_dep = 0;
`else
        exp_lu  = DEPTH;
        exp_dep = DEPTH;
`endif
        sbif.d_valid = 0; sbif.d_rs = '0; sbif.d_rt = '0; sbif.d_rs_used = 0;
        sbif.d_rt_used = 0; sbif.d_rd = '0; sbif.d_reg_write_en = 0;
        sbif.d_mem_read_en = 0; sbif.flush = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        check_val("rst_stall",  32'(sbif.stall),      0);
        check_val("rst_rs_sel", 32'(sbif.fwd_rs_sel), 0);
        check_val("rst_rt_sel", 32'(sbif.fwd_rt_sel), 0);
        check_val("rst_cnt",    32'(sbif.stall_cnt),  0);

        // Load-use
        issue(lw3, n);
        issue(use3, n);
        check_val("load_use_stalls", n, exp_lu);
        drain();
        // ALU to ALU, both sources
        issue(mk(1, 1, 1, 1, 1, 2, 1, 0, 0), n);
        issue(mk(1, 2, 2, 1, 1, 6, 1, 0, 0), n);
        check_val("alu_dep_stalls", n, exp_dep);
        drain();
        // Zero register never hazards
        issue(mk(1, 1, 1, 1, 1, 0, 1, 0, 0), n);
        issue(mk(1, 0, 0, 1, 1, 7, 1, 0, 0), n);
        check_val("zero_reg_stalls", n, 0);
        drain();
        // Flush during hazard
        issue(lw3, n);
        cnt_before = cnt_m;
        step(mk(1, 3, 3, 1, 1, 4, 1, 0, 1), 1'b0, s);
        check_val("flush_stall", 32'(obs_stall), 0);
        step(nop, 1'b0, s);
        check_val("flush_cnt_hold", obs_cnt, cnt_before);
        drain();

        // Saturation of the 2-bit counter, then reset mid-stall
        step(nop, 1'b1, s);
        repeat (5) begin
            issue(lw3, n);
            issue(use3, n);
        end
        step(nop, 1'b0, s);
        check_val("cnt2_saturated", 32'(sbif2.stall_cnt), 3);
        check_val("cnt_total", obs_cnt, 5 * exp_lu);
        issue(lw3, n);
        step(use3, 1'b0, s);
        check_val("stall_before_rst", 32'(obs_stall), 1);
        step(use3, 1'b1, s);
        step(use3, 1'b0, s);
        check_val("post_rst_stall", 32'(obs_stall), 0);
        check_val("post_rst_cnt", obs_cnt, 0);
        check_val("post_rst_cnt2", 32'(sbif2.stall_cnt), 0);

        // Random phase: decode holds its instruction while stalled
        last_stall = 0;
        cur = nop;
        for (int t = 0; t < 300; t++) begin
            if (!last_stall) begin
                cur = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                         $urandom_range(0, 9) < 3, 1'b0);
            end
            cur.flush = ($urandom_range(0, 9) == 0);
            step(cur, $urandom_range(0, 49) == 0, last_stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
